// File: rtl/multiphase_clk_gen.sv
// Multi-phase clock generator: NUM_PHASES evenly spaced 50%-duty phases, each step DIV+1 clks,
// with glitch-free start/stop at period boundaries, a period sync pulse and status outputs.
module multiphase_clk_gen #(
  parameter int unsigned NUM_PHASES = 4,
  parameter int unsigned DIV_W      = 8,
  localparam int unsigned StepW     = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIV_W-1:0]      div,
  output logic [NUM_PHASES-1:0] phase_out,
  output logic                  sync,
  output logic                  busy,
  output logic [StepW-1:0]      cur_step
);

  localparam int unsigned K = NUM_PHASES / 2;
  localparam logic [StepW-1:0] LastStep = StepW'(NUM_PHASES - 1);
  localparam logic [StepW-1:0] KStep    = StepW'(K);
  localparam logic [StepW-1:0] KM1Step  = StepW'(K - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [StepW-1:0]        step_q, step_d;
  logic [DIV_W-1:0]        presc_q, presc_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [NUM_PHASES-1:0]   phase_q, phase_d;
  logic                    sync_q, sync_d;
  logic [StepW-1:0]        step_nxt;
  logic [StepW-1:0]        fall_idx;

  always_comb begin
    step_nxt = (step_q == LastStep) ? '0 : step_q + StepW'(1);
    // Phase p falls on entry to step p+K, so the phase falling at step n is n-K mod 2K.
    fall_idx = (step_nxt >= KStep) ? step_nxt - KStep : step_nxt + KStep;
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    presc_d = presc_q;
    div_d   = div_q;
    phase_d = phase_q;
    sync_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d    = StRun;
          div_d      = div;
          presc_d    = '0;
          step_d     = '0;
          phase_d[0] = 1'b1;
          sync_d     = 1'b1;
        end
      end
      StRun, StDrain: begin
        if (presc_q == div_q) begin
          presc_d           = '0;
          step_d            = step_nxt;
          phase_d[fall_idx] = 1'b0;
          if (state_q == StRun) begin
            if (step_nxt == '0 && !en) begin
              state_d = StDrain;
            end else begin
              phase_d[step_nxt] = 1'b1;
              if (step_nxt == '0) begin
                div_d  = div;
                sync_d = 1'b1;
              end
            end
          end
          // Once step K-1 is entered in drain every phase has fallen.
          if (state_d == StDrain && step_nxt == KM1Step) begin
            state_d = StIdle;
            step_d  = '0;
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      presc_q <= '0;
      div_q   <= '0;
      phase_q <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

  assign phase_out = phase_q;
  assign sync      = sync_q;
  assign busy      = (state_q != StIdle);
  assign cur_step  = step_q;

endmodule

// File: tb/tb_multiphase_clk_gen.sv
// Scoreboard bench for multiphase_clk_gen: expected per-cycle outputs are derived from the
// analytic waveform (phase p high while its step window is open) and compared every clock.
module tb_multiphase_clk_gen;

  logic       clk = 1'b0;
  logic       rst4 = 1'b1, rst8 = 1'b1, rst2 = 1'b1;
  logic       en = 1'b0;
  logic [7:0] div = '0;
  int         sel = 0;

  logic [3:0] ph4;  logic s4, b4; logic [1:0] st4;
  logic [7:0] ph8;  logic s8, b8; logic [2:0] st8;
  logic [1:0] ph2;  logic s2, b2; logic [0:0] st2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [38:0] sb[$];
  logic [38:0] obs;

  always #5 clk = ~clk;

  multiphase_clk_gen #(.NUM_PHASES(4), .DIV_W(8)) u_dut4 (
    .clk(clk), .rst(rst4), .en(en), .div(div),
    .phase_out(ph4), .sync(s4), .busy(b4), .cur_step(st4)
  );
  multiphase_clk_gen #(.NUM_PHASES(8), .DIV_W(8)) u_dut8 (
    .clk(clk), .rst(rst8), .en(en), .div(div),
    .phase_out(ph8), .sync(s8), .busy(b8), .cur_step(st8)
  );
  multiphase_clk_gen #(.NUM_PHASES(2), .DIV_W(8)) u_dut2 (
    .clk(clk), .rst(rst2), .en(en), .div(div),
    .phase_out(ph2), .sync(s2), .busy(b2), .cur_step(st2)
  );

  // Observed vector: {phase[31:0], sync, busy, step[4:0]}
  always_comb begin
    obs = '0;
    case (sel)
      0:       obs = {32'(ph4), s4, b4, 5'(st4)};
      1:       obs = {32'(ph8), s8, b8, 5'(st8)};
      default: obs = {32'(ph2), s2, b2, 5'(st2)};
    endcase
  end

  task automatic check_val(input string tag, input logic [38:0] got, input logic [38:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got ph=%h sync=%b busy=%b step=%0d, want ph=%h sync=%b busy=%b step=%0d",
               tag, $time, got[38:7], got[6], got[5], got[4:0],
               exp[38:7], exp[6], exp[5], exp[4:0]);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_sb_empty @%0t: got ph=%h, want none", tag, $time, obs[38:7]);
    end else begin
      check_val(tag, obs, sb.pop_front());
    end
  endtask

  // One running period; phases >= K carry the tail of the previous period unless first.
  task automatic push_run(input int k, input int l, input bit first, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int s;
      logic [31:0] ph;
      s  = c / l;
      ph = '0;
      for (int p = 0; p < 2 * k; p++)
        ph[p] = (s >= p && s < p + k) || (!first && p >= k && s < p - k);
      sb.push_back({ph, (c == 0), 1'b1, 5'(s)});
    end
  endtask

  task automatic run_period(input int k, input int l, input bit first);
    push_run(k, l, first, 2 * k * l);
    for (int c = 0; c < 2 * k * l; c++) begin
      if (c == 0) begin
        en  = 1'b1;
        div = 8'(l - 1);
      end else begin
        en  = 1'($urandom_range(0, 1));
        div = 8'($urandom_range(0, 255));
      end
      tick("run");
    end
  endtask

  task automatic drain(input int k, input int l);
    int nd;
    nd = (k - 1) * l;
    for (int c = 0; c < nd; c++) begin
      int s;
      logic [31:0] ph;
      s  = c / l;
      ph = '0;
      for (int p = k; p < 2 * k; p++) ph[p] = (s < p - k);
      sb.push_back({ph, 1'b0, 1'b1, 5'(s)});
    end
    sb.push_back('0);
    for (int c = 0; c <= nd; c++) begin
      if (c == 0) en = 1'b0;
      else if (c == nd) en = 1'b1;
      else en = 1'($urandom_range(0, 1));
      div = 8'($urandom_range(0, 255));
      tick("drain");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back('0);
      en = 1'b0;
      tick("idle");
    end
  endtask

  initial begin
    #2;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      check_val("reset_state", obs, '0);
    end

    // NUM_PHASES=4
    sel = 0;
    @(posedge clk); #1;
    rst4 = 1'b0;
    idle(2);
    run_period(2, 1, 1'b1);
    run_period(2, 1, 1'b0);
    drain(2, 1);
    idle(2);
    run_period(2, 3, 1'b1);
    run_period(2, 6, 1'b0);
    drain(2, 6);
    run_period(2, 1, 1'b1);
    drain(2, 1);
    idle(1);

    // Reset mid-run at step 2, then restart from step 0
    push_run(2, 1, 1'b1, 3);
    en  = 1'b1;
    div = 8'd0;
    for (int c = 0; c < 3; c++) tick("pre_rst");
    rst4 = 1'b1;
    #1;
    check_val("rst_async", obs, '0);
    @(posedge clk); #1;
    check_val("rst_held", obs, '0);
    en   = 1'b0;
    rst4 = 1'b0;
    idle(1);
    run_period(2, 1, 1'b1);
    run_period(2, 2, 1'b0);
    drain(2, 2);
    idle(1);

    // NUM_PHASES=8, div=1
    rst4 = 1'b1;
    sel  = 1;
    rst8 = 1'b0;
    idle(1);
    run_period(4, 2, 1'b1);
    run_period(4, 2, 1'b0);
    drain(4, 2);
    idle(2);

    // NUM_PHASES=2, div=0
    rst8 = 1'b1;
    sel  = 2;
    rst2 = 1'b0;
    idle(1);
    run_period(1, 1, 1'b1);
    run_period(1, 1, 1'b0);
    run_period(1, 1, 1'b0);
    drain(1, 1);
    idle(2);
    run_period(1, 3, 1'b1);
    drain(1, 3);
    idle(1);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multiphase_clk_gen.md
Name: multiphase_clk_gen

Overview:
- Parametrised multi-phase clock generator.
- Produces NUM_PHASES equally spaced, 50%-duty phase outputs derived from clk.
- Phase spacing is one "step"; each step lasts DIV+1 clk cycles, with DIV programmable per period.
- Adds glitch-free start/stop, a period sync pulse and status outputs.
- Sits beside the clock/reset logic and feeds sampling and strobe logic that needs phase-shifted enables.

Parameters:
- NUM_PHASES, 4, number of phase outputs; even, 2..32. K = NUM_PHASES/2.
- DIV_W, 8, width of the step-length divider input.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run request; sampled at period boundaries only
- div  in  DIV_W  step length minus one; latched at each period start
- phase_out  out  NUM_PHASES  phase outputs; phase p delayed p steps from phase 0
- sync  out  1  one-clk pulse at every period start while running
- busy  out  1  high whenever the state is not IDLE
- cur_step  out  $clog2(NUM_PHASES) (min 1)  current step index s

Behaviour:
- Reset (async) values: state=IDLE, s=0, prescaler=0, div_q=0, phase_out=0, sync=0, busy=0.
  - Assertion mid-operation forces all outputs low immediately; no drain.
- Period = 2K steps = 2K*(div_q+1) clk cycles. Step index s counts 0..2K-1, then wraps.
- Output edges are registered and occur only at a step-entry edge:
  - phase_out[p] rises only on entry to s=p (RUN only).
  - phase_out[p] falls only on entry to s=(p+K) mod 2K (RUN or DRAIN).
  - No other output transitions are allowed, so outputs are glitch-free.
- Prescaler:
  - Counts 0..div_q.
  - On the edge where prescaler==div_q: prescaler<=0, s<=s+1 mod 2K, apply the rise/fall rules for the new s.
- States:
  - IDLE: s=0, outputs low. On an edge with en=1: state->RUN, div_q<=div, prescaler<=0, s=0, phase_out[0] rises, sync=1 for that cycle.
  - RUN: steps advance as above.
    - On wrap 2K-1->0 with en=1: stay RUN, div_q<=div, phase_out[0] rises, sync pulses.
    - On wrap with en=0: state->DRAIN, phase_out[K] falls, no rise, no sync.
  - DRAIN: steps continue; falls still apply, rises are suppressed. On entry to s=K-1 (after its falls), state->IDLE, s<=0, prescaler<=0.
    - For K=1 this happens at the wrap edge itself; the design goes straight to IDLE.
- en is ignored except in IDLE and at the wrap edge. Toggling en mid-period has no effect.
- div changes mid-period are ignored until the next period start.
- First period after start: phases K..2K-1 stay low until their own rise step (no partial pulses).
- busy=1 in RUN and DRAIN, registered with the state.
- cur_step mirrors s.
- en=1 in the same cycle DRAIN reaches IDLE: the new start is taken on the following edge, from IDLE.

Test Plan:
- NUM_PHASES=4, div=0, en=1 at edge E0:
  - phase0 rises E0, phase1 E1, phase2 E2, phase3 E3.
  - phase0 falls E2, phase1 E3, phase2 E4, phase3 E5.
  - sync at E0 and E4; period 4 clk.
- Same setup, en dropped before E4:
  - E4 enters DRAIN, phase2 falls, no sync.
  - E5 phase3 falls, busy=0 after E5.
  - All phases low; no extra rises.
- div=2 latched at E0, div written to 5 mid-period:
  - Steps last 3 clk in period 1 (period 12 clk).
  - Steps last 6 clk from the next period (period 24 clk).
- NUM_PHASES=8, div=1:
  - Phase p rises at clk offset 2p, duty exactly 8 clk high / 8 clk low.
  - Phases 4..7 stay low before their first rise.
- rst asserted mid-RUN at s=2:
  - phase_out=0, busy=0, sync=0 immediately.
  - After release with en=1, restart begins at s=0 with phase0 rising.
- NUM_PHASES=2, div=0, en toggled 1->0:
  - Square wave and its complement at clk/2.
  - Stop returns to IDLE at the wrap edge with both outputs low.
